// File: rtl/ifft16_radix4.sv
// 16-point radix-4 DIT inverse FFT engine with one time-shared butterfly.
// A frame is loaded in base-4 digit-reversed order, run through two
// in-place butterfly passes (S1 with unity twiddles, S2 with W16^-k),
// then drained in natural order.
// Optional build macro: IFFT_SCALE_EN -- each butterfly output is divided
// by 4 (floor), so a full frame is scaled by 1/16 and yields the true IDFT.
// Without it the outputs are 16*IDFT, truncated to DATA_W and free to wrap.
//
// state | meaning
// LOAD  | accept x[0..15] into mem, digit-reversed
// S1    | pass 1: butterfly on mem[4p..4p+3], p = 0..3
// S2    | pass 2: twiddled butterfly on mem[p], mem[p+4], mem[p+8], mem[p+12]
// DRAIN | stream X[0..15] from mem, m_last on X[15]

module ifft16_radix4 #(
    parameter int DATA_W  = 17,
    parameter int TW_W    = 8,
    parameter int TW_FRAC = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [2*DATA_W-1:0]   s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*DATA_W-1:0]   m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int SW = DATA_W + 2;
    localparam int PW = DATA_W + TW_W + 1;

    typedef enum logic [1:0] {LOAD, S1, S2, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic [2*DATA_W-1:0] mem [16];

    logic [3:0]          addr [4];
    logic [2*DATA_W-1:0] opnd [4];
    logic [2*DATA_W-1:0] res  [4];
    logic [3:0]          kk;
    logic signed [SW-1:0] ar, ai, br, bi, cr, ci, dr, di;

    // W16^-k = cos + j*sin(2*pi*k/16) as {re, im}; only the k values S2 can reach
    function automatic logic [2*TW_W-1:0] twiddle(input logic [3:0] k);
        case (k)
            4'd1:    return {8'h76, 8'h31};
            4'd2:    return {8'h5A, 8'h5A};
            4'd3:    return {8'h31, 8'h76};
            4'd4:    return {8'h00, 8'h7F};
            4'd6:    return {8'hA6, 8'h5A};
            4'd9:    return {8'h8A, 8'hCF};
            default: return {8'h7F, 8'h00};
        endcase
    endfunction

    // full-width complex product, arithmetic shift, then truncate to DATA_W
    function automatic logic [2*DATA_W-1:0] cmul(input logic [2*DATA_W-1:0] x,
                                                 input logic [2*TW_W-1:0] w);
        logic signed [PW-1:0] xr, xi, wr, wi, pr, pi;
        xr = PW'($signed(x[2*DATA_W-1:DATA_W]));
        xi = PW'($signed(x[DATA_W-1:0]));
        wr = PW'($signed(w[2*TW_W-1:TW_W]));
        wi = PW'($signed(w[TW_W-1:0]));
        pr = (xr * wr - xi * wi) >>> TW_FRAC;
        pi = (xr * wi + xi * wr) >>> TW_FRAC;
        return {pr[DATA_W-1:0], pi[DATA_W-1:0]};
    endfunction

    // butterfly sum back to DATA_W, with optional divide-by-4
    function automatic logic [DATA_W-1:0] fit(input logic signed [SW-1:0] s);
`ifdef IFFT_SCALE_EN
        logic signed [SW-1:0] t;
        t = s >>> 2;
        return t[DATA_W-1:0];
`else
        return s[DATA_W-1:0];
`endif
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // next state and stream handshake outputs
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        busy    = 1'b1;
        case (state_q)
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid && cnt_q == 4'd15) state_d = S1;
            end
            S1: begin
                if (cnt_q[1:0] == 2'd3) state_d = S2;
            end
            S2: begin
                if (cnt_q[1:0] == 2'd3) state_d = DRAIN;
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_data  = mem[cnt_q];
                m_last  = (cnt_q == 4'd15);
                if (m_ready && cnt_q == 4'd15) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // operand fetch, S2 twiddles and the inverse (+j) butterfly
    always_comb begin
        kk = '0;
        for (int k = 0; k < 4; k++) begin
            addr[k] = (state_q == S2) ? {2'(k), cnt_q[1:0]} : {cnt_q[1:0], 2'(k)};
            opnd[k] = mem[addr[k]];
            if (state_q == S2) begin
                kk = 4'(k) * {2'b00, cnt_q[1:0]};
                if (kk != 4'd0) opnd[k] = cmul(mem[addr[k]], twiddle(kk));
            end
        end
        ar = SW'($signed(opnd[0][2*DATA_W-1:DATA_W]));
        ai = SW'($signed(opnd[0][DATA_W-1:0]));
        br = SW'($signed(opnd[1][2*DATA_W-1:DATA_W]));
        bi = SW'($signed(opnd[1][DATA_W-1:0]));
        cr = SW'($signed(opnd[2][2*DATA_W-1:DATA_W]));
        ci = SW'($signed(opnd[2][DATA_W-1:0]));
        dr = SW'($signed(opnd[3][2*DATA_W-1:DATA_W]));
        di = SW'($signed(opnd[3][DATA_W-1:0]));
        res[0] = {fit(ar + br + cr + dr), fit(ai + bi + ci + di)};
        res[1] = {fit(ar - bi - cr + di), fit(ai + br - ci - dr)};
        res[2] = {fit(ar - br + cr - dr), fit(ai - bi + ci - di)};
        res[3] = {fit(ar + bi - cr - di), fit(ai - br - ci + dr)};
    end

    // sample counter / pass index / drain index, and frame storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (s_valid) begin
                        mem[{cnt_q[1:0], cnt_q[3:2]}] <= s_data;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S1, S2: begin
                    for (int k = 0; k < 4; k++) mem[addr[k]] <= res[k];
                    cnt_q <= (cnt_q[1:0] == 2'd3) ? 4'd0 : cnt_q + 4'd1;
                end
                DRAIN: begin
                    if (m_ready) cnt_q <= cnt_q + 4'd1;
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft16_radix4.sv
// Directed bench for ifft16_radix4: impulse, DC, +j sign, twiddle paths,
// backpressure, mid-frame reset, and (scaled build) headroom.
module tb_ifft16_radix4;

    localparam int DATA_W = 17;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [2*DATA_W-1:0] s_data = '0;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic [2*DATA_W-1:0] m_data;
    logic                m_last;
    logic                busy;

    ifft16_radix4 dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    logic [2*DATA_W-1:0] xin  [16];
    logic [2*DATA_W-1:0] expv [16];
    logic [2*DATA_W-1:0] got  [16];
    int                  n_got, first_cyc, hs_cyc, stall_bad, sready_bad;
    logic [15:0]         last_mask;

    function automatic logic [2*DATA_W-1:0] mk(input int re, input int im);
        logic [DATA_W-1:0] r, i;
        r = re[DATA_W-1:0];
        i = im[DATA_W-1:0];
        return {r, i};
    endfunction

    task automatic send_frame();
        int w;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = xin[i];
            w = 0;
            while (s_ready !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout sample %0d: s_ready stayed low", i);
            end
            hs_cyc = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic collect(input bit bp);
        logic [2*DATA_W-1:0] pd;
        logic                pl;
        bit                  stalled;
        int                  t, vcount;
        n_got = 0; first_cyc = -1; stall_bad = 0; sready_bad = 0;
        last_mask = '0; stalled = 0; t = 0; vcount = 0;
        pd = '0; pl = 1'b0;
        while (n_got < 16 && t < 300) begin
            @(negedge clk);
            t++;
            if (m_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stalled && (m_data !== pd || m_last !== pl)) stall_bad++;
                if (s_ready !== 1'b0) sready_bad++;
                m_ready = bp ? (vcount % 2 == 0) : 1'b1;
                vcount++;
                if (m_ready) begin
                    got[n_got] = m_data;
                    if (m_last === 1'b1) last_mask[n_got] = 1'b1;
                    n_got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = m_data;
                    pl = m_last;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got s_ready=%b m_valid=%b m_last=%b busy=%b m_data=%h, need 1 0 0 0 0",
                     s_ready, m_valid, m_last, busy, m_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        for (int i = 0; i < 16; i++) xin[i] = '0;
        xin[0] = mk(1000, 0);
`ifdef IFFT_SCALE_EN
        for (int i = 0; i < 16; i++) expv[i] = mk(62, 0);
`else
        for (int i = 0; i < 16; i++) expv[i] = mk(1000, 0);
`endif
        send_frame();
        collect(1'b0);
        n_checks++;
        if (n_got != 16) begin n_fail++; $display("FAIL impulse_count: got %0d outputs, need 16", n_got); end
        n_checks++;
        if (first_cyc - hs_cyc != 9) begin
            n_fail++; $display("FAIL impulse_latency: got %0d cycles, need 9", first_cyc - hs_cyc);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[i] !== expv[i]) begin
                n_fail++; $display("FAIL impulse X[%0d]: got %h, need %h", i, got[i], expv[i]);
            end
        end
        n_checks++;
        if (last_mask !== 16'h8000) begin n_fail++; $display("FAIL impulse_last: got mask %h, need 8000", last_mask); end
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL impulse_return_load: got m_valid=%b s_ready=%b busy=%b, need 0 1 0", m_valid, s_ready, busy);
        end
    endtask

    task automatic test_dc();
        for (int i = 0; i < 16; i++) begin xin[i] = mk(100, 0); expv[i] = '0; end
`ifdef IFFT_SCALE_EN
        expv[0] = mk(100, 0);
`else
        expv[0] = mk(1600, 0);
`endif
        send_frame();
        collect(1'b0);
        n_checks++;
        if (n_got != 16) begin n_fail++; $display("FAIL dc_count: got %0d outputs, need 16", n_got); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[i] !== expv[i]) begin
                n_fail++; $display("FAIL dc X[%0d]: got %h, need %h", i, got[i], expv[i]);
            end
        end
    endtask

`ifndef IFFT_SCALE_EN
    task automatic test_sign();
        for (int i = 0; i < 16; i++) xin[i] = '0;
        xin[4] = mk(1000, 0);
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: expv[i] = mk(1000, 0);
                1: expv[i] = mk(0, 1000);
                2: expv[i] = mk(-1000, 0);
                default: expv[i] = mk(0, -1000);
            endcase
        end
        send_frame();
        collect(1'b0);
        n_checks++;
        if (n_got != 16) begin n_fail++; $display("FAIL sign_count: got %0d outputs, need 16", n_got); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[i] !== expv[i]) begin
                n_fail++; $display("FAIL sign X[%0d]: got %h, need %h", i, got[i], expv[i]);
            end
        end
    endtask

    task automatic test_twiddle();
        int er1 [16] = '{1000, 921, 703, 382, 0, -382, -703, -921, -1000, -921, -703, -382, 0, 382, 703, 921};
        int ei1 [16] = '{0, 382, 703, 921, 1000, 921, 703, 382, 0, -382, -703, -921, -1000, -921, -703, -382};
        int er2 [16] = '{1000, 703, 0, -704, -1000, -703, 0, 704, 1000, 703, 0, -704, -1000, -703, 0, 704};
        int ei2 [16] = '{0, 703, 992, 703, 0, -703, -992, -703, 0, 703, 992, 703, 0, -703, -992, -703};
        for (int f = 1; f <= 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                xin[i] = '0;
                expv[i] = (f == 1) ? mk(er1[i], ei1[i]) : mk(er2[i], ei2[i]);
            end
            xin[f] = mk(1000, 0);
            send_frame();
            collect(1'b0);
            n_checks++;
            if (n_got != 16) begin n_fail++; $display("FAIL twiddle%0d_count: got %0d outputs, need 16", f, n_got); end
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (got[i] !== expv[i]) begin
                    n_fail++; $display("FAIL twiddle x[%0d] X[%0d]: got %h, need %h", f, i, got[i], expv[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) xin[i] = '0;
        xin[0] = mk(1000, 0);
`ifdef IFFT_SCALE_EN
        for (int i = 0; i < 16; i++) expv[i] = mk(62, 0);
`else
        for (int i = 0; i < 16; i++) expv[i] = mk(1000, 0);
`endif
        send_frame();
        collect(1'b1);
        n_checks++;
        if (n_got != 16) begin n_fail++; $display("FAIL bp_count: got %0d outputs, need 16", n_got); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[i] !== expv[i]) begin
                n_fail++; $display("FAIL bp X[%0d]: got %h, need %h", i, got[i], expv[i]);
            end
        end
        n_checks++;
        if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled, need 0", stall_bad); end
        n_checks++;
        if (sready_bad != 0) begin n_fail++; $display("FAIL bp_sready: got %0d drain cycles with s_ready high, need 0", sready_bad); end
        n_checks++;
        if (last_mask !== 16'h8000) begin n_fail++; $display("FAIL bp_last: got mask %h, need 8000", last_mask); end
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_return_load: got m_valid=%b s_ready=%b, need 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) xin[i] = '0;
        xin[0] = mk(1000, 0);
        send_frame();
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_busy: got busy=%b s_ready=%b, need 1 0", busy, s_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || m_last !== 1'b0) begin
            n_fail++; $display("FAIL midrst_values: got m_valid=%b s_ready=%b busy=%b m_last=%b, need 0 1 0 0",
                               m_valid, s_ready, busy, m_last);
        end
        rst_n = 1'b1;
`ifdef IFFT_SCALE_EN
        for (int i = 0; i < 16; i++) expv[i] = mk(62, 0);
`else
        for (int i = 0; i < 16; i++) expv[i] = mk(1000, 0);
`endif
        send_frame();
        collect(1'b0);
        n_checks++;
        if (first_cyc - hs_cyc != 9) begin
            n_fail++; $display("FAIL midrst_latency: got %0d cycles, need 9", first_cyc - hs_cyc);
        end
        n_checks++;
        if (n_got != 16) begin n_fail++; $display("FAIL midrst_count: got %0d outputs, need 16", n_got); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[i] !== expv[i]) begin
                n_fail++; $display("FAIL midrst X[%0d]: got %h, need %h", i, got[i], expv[i]);
            end
        end
    endtask

`ifdef IFFT_SCALE_EN
    task automatic test_headroom();
        for (int i = 0; i < 16; i++) begin xin[i] = mk(40000, 0); expv[i] = '0; end
        expv[0] = mk(40000, 0);
        send_frame();
        collect(1'b0);
        n_checks++;
        if (n_got != 16) begin n_fail++; $display("FAIL headroom_count: got %0d outputs, need 16", n_got); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[i] !== expv[i]) begin
                n_fail++; $display("FAIL headroom X[%0d]: got %h, need %h", i, got[i], expv[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_impulse();
        test_dc();
`ifndef IFFT_SCALE_EN
        test_sign();
        test_twiddle();
`endif
        test_backpressure();
        test_reset_mid();
`ifdef IFFT_SCALE_EN
        test_headroom();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
